memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
REQ-003 SHALL have ports: imem_req_valid in 1, imem_req_addr in 32, imem_req_ready out 1, imem_resp_valid out 1, imem_resp_data out 32 (fetch requester, read-only).
REQ-004 SHALL have ports: dmem_req_valid in 1, dmem_req_addr in 32, dmem_req_fcn in Bundle::MemoryWriteSignal, dmem_req_typ in Bundle::MemoryMaskType, dmem_req_wdata in 32, dmem_req_ready out 1, dmem_resp_valid out 1, dmem_resp_data out 32 (data requester).
REQ-005 SHALL have ports: mem_req_valid out 1, mem_req_ready in 1, mem_req_addr out 32, mem_req_fcn out MemoryWriteSignal, mem_req_typ out MemoryMaskType, mem_req_wdata out 32, mem_resp_valid in 1, mem_resp_data in 32 (shared single-port memory).
REQ-006 SHALL have port: cmiss_stall out 1, high while any requester holds an unserved request or an outstanding transaction exists.

Function
REQ-007 SHALL implement FSM states IDLE, BUSY_I, BUSY_D (enum in package); at most one outstanding memory transaction.
REQ-008 In IDLE, SHALL drive mem_req_* from the granted requester; imem fetch forced to fcn=M_XRD, typ=MT_W, wdata=0.
REQ-009 Grant: only one requester valid -> that one; both valid -> dmem unless last_owner==D, then imem (alternating on conflict).
REQ-010 Handshake: transfer occurs when mem_req_valid && mem_req_ready; granted port's req_ready = (state==IDLE) && mem_req_ready, combinational; non-granted req_ready=0.
REQ-011 On transfer: state -> BUSY_I or BUSY_D next cycle; last_owner updated to the granted side.
REQ-012 In BUSY_x, mem_req_valid=0; requests held, not accepted.
REQ-013 On mem_resp_valid in BUSY_x: x_resp_valid=1 and x_resp_data=mem_resp_data same cycle (combinational route); other port resp_valid=0; state -> IDLE next cycle.
REQ-014 Stores SHALL also return a response (ack); dmem_resp_data don't-care, driven to mem_resp_data.
REQ-015 mem_resp_valid in IDLE SHALL be ignored (no resp_valid to either port).
REQ-016 Latency: request in cycle N with mem_req_ready=1 and response in N+1 -> resp_valid in N+1; next grant earliest N+2.
REQ-017 Requester dropping valid in IDLE before transfer SHALL lose grant without side effect; arbitration re-evaluated every IDLE cycle.
REQ-018 cmiss_stall = (state!=IDLE && !mem_resp_valid) || (state==IDLE && (imem_req_valid || dmem_req_valid) && !transfer) || (both valid in IDLE, for the loser).
REQ-019 mem_req_valid=0 when neither requester valid; mem_req_* outputs SHALL be 0 then.

Reset
REQ-020 On reset=0: state=IDLE, last_owner=I (so first conflict grants dmem), all outputs 0 including cmiss_stall.
REQ-021 Reset asserted mid-transaction SHALL abandon it; a late mem_resp_valid after reset release SHALL be ignored per REQ-015.
REQ-022 Deassertion SHALL be synchronised externally; first arbitration at first rising edge with reset=1.

Structure
REQ-023 ArbState enum (IDLE, BUSY_I, BUSY_D) and ArbOwner enum (OWN_I, OWN_D) SHALL be added to package Bundle; M_XRD, MT_W reused from Bundle.
REQ-024 SHALL be a single module, no sub-modules; one always_ff for state/last_owner, combinational grant/route logic.

Verification
REQ-025 Imem only: imem_req addr 0x100, ready=1, resp next cycle 0xDEADBEEF -> imem_resp_valid=1 data 0xDEADBEEF, dmem_resp_valid=0.
REQ-026 Simultaneous imem 0x200 and dmem store 0x400 data 0x55 after reset -> dmem issued first (fcn write, wdata 0x55), imem issued after dmem ack; repeat conflict -> order alternates D, I, D, I.
REQ-027 mem_req_ready=0 for 3 cycles with dmem valid -> mem_req_valid=1 held stable, dmem_req_ready=0, cmiss_stall=1 all 3 cycles; transfer on 4th.
REQ-028 Response delayed 5 cycles in BUSY_I while dmem valid -> mem_req_valid=0 throughout, dmem granted cycle after imem response.
REQ-029 reset=0 pulsed in BUSY_D -> outputs 0 immediately; later stray mem_resp_valid -> no resp_valid on either port.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared memory-interface types for the core's memory system.
// Holds the request function/mask encodings plus the arbiter's state and owner enums.
package Bundle;

  typedef enum logic {
    M_XRD = 1'b0,
    M_XWR = 1'b1
  } MemoryWriteSignal;

  typedef enum logic [2:0] {
    MT_X  = 3'd0,
    MT_B  = 3'd1,
    MT_H  = 3'd2,
    MT_W  = 3'd3,
    MT_BU = 3'd4,
    MT_HU = 3'd5
  } MemoryMaskType;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } ArbState;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } ArbOwner;

endpackage

// File: rtl/memory_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-port memory.
// Only one transaction is outstanding at a time, and conflicts alternate between the two requesters.
module memory_arbiter
  import Bundle::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_req_valid,
  input  logic [31:0]      imem_req_addr,
  output logic             imem_req_ready,
  output logic             imem_resp_valid,
  output logic [31:0]      imem_resp_data,
  input  logic             dmem_req_valid,
  input  logic [31:0]      dmem_req_addr,
  input  MemoryWriteSignal dmem_req_fcn,
  input  MemoryMaskType    dmem_req_typ,
  input  logic [31:0]      dmem_req_wdata,
  output logic             dmem_req_ready,
  output logic             dmem_resp_valid,
  output logic [31:0]      dmem_resp_data,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [31:0]      mem_req_addr,
  output MemoryWriteSignal mem_req_fcn,
  output MemoryMaskType    mem_req_typ,
  output logic [31:0]      mem_req_wdata,
  input  logic             mem_resp_valid,
  input  logic [31:0]      mem_resp_data,
  output logic             cmiss_stall
);

  ArbState state;
  ArbOwner last_owner;

  logic idle;
  logic busy;
  logic any_req;
  logic grant_d;
  logic transfer;

  // Every output is qualified by reset, so holding reset low forces all outputs to zero at once.
  always_comb begin
    idle     = reset && (state == IDLE);
    busy     = reset && (state != IDLE);
    any_req  = imem_req_valid || dmem_req_valid;
    grant_d  = dmem_req_valid && !(imem_req_valid && (last_owner == OWN_D));
    transfer = idle && any_req && mem_req_ready;

    mem_req_valid = idle && any_req;
    mem_req_addr  = 32'd0;
    mem_req_fcn   = M_XRD;
    mem_req_typ   = MT_X;
    mem_req_wdata = 32'd0;
    if (mem_req_valid) begin
      if (grant_d) begin
        mem_req_addr  = dmem_req_addr;
        mem_req_fcn   = dmem_req_fcn;
        mem_req_typ   = dmem_req_typ;
        mem_req_wdata = dmem_req_wdata;
      end else begin
        mem_req_addr = imem_req_addr;
        mem_req_typ  = MT_W;
      end
    end

    dmem_req_ready = idle && grant_d && mem_req_ready;
    imem_req_ready = idle && imem_req_valid && !grant_d && mem_req_ready;

    imem_resp_valid = busy && (state == BUSY_I) && mem_resp_valid;
    dmem_resp_valid = busy && (state == BUSY_D) && mem_resp_valid;
    imem_resp_data  = imem_resp_valid ? mem_resp_data : 32'd0;
    dmem_resp_data  = dmem_resp_valid ? mem_resp_data : 32'd0;

    cmiss_stall = (busy && !mem_resp_valid)
               || (idle && any_req && !transfer)
               || (idle && imem_req_valid && dmem_req_valid);
  end

  // The owner flop remembers who won last, so the next conflict goes to the other side.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_owner <= OWN_I;
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            state      <= grant_d ? BUSY_D : BUSY_I;
            last_owner <= grant_d ? OWN_D : OWN_I;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_resp_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus random traffic, all checked every cycle
// against a transaction-level model of who owns the memory and who should win next.
module tb_memory_arbiter;
  import Bundle::*;

  logic             clk;
  logic             reset;
  logic             imem_req_valid;
  logic [31:0]      imem_req_addr;
  logic             imem_req_ready;
  logic             imem_resp_valid;
  logic [31:0]      imem_resp_data;
  logic             dmem_req_valid;
  logic [31:0]      dmem_req_addr;
  MemoryWriteSignal dmem_req_fcn;
  MemoryMaskType    dmem_req_typ;
  logic [31:0]      dmem_req_wdata;
  logic             dmem_req_ready;
  logic             dmem_resp_valid;
  logic [31:0]      dmem_resp_data;
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [31:0]      mem_req_addr;
  MemoryWriteSignal mem_req_fcn;
  MemoryMaskType    mem_req_typ;
  logic [31:0]      mem_req_wdata;
  logic             mem_resp_valid;
  logic [31:0]      mem_resp_data;
  logic             cmiss_stall;

  int n_compared;
  int n_mismatched;

  // Model: which side holds the memory (0 none, 1 imem, 2 dmem) and whether dmem won last.
  int m_pending;
  bit m_last_d;
  bit e_transfer;
  bit e_pick_d;

  memory_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_addr   (dmem_req_addr),
    .dmem_req_fcn    (dmem_req_fcn),
    .dmem_req_typ    (dmem_req_typ),
    .dmem_req_wdata  (dmem_req_wdata),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_resp_data  (dmem_resp_data),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_req_fcn     (mem_req_fcn),
    .mem_req_typ     (mem_req_typ),
    .mem_req_wdata   (mem_req_wdata),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data),
    .cmiss_stall     (cmiss_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, actual, expected);
    end
  endtask

  task automatic checkModel();
    bit any;
    bit both;
    bit idle;
    logic [31:0] e_addr, e_wdata, e_fcn, e_typ, e_irdata, e_drdata;
    bit e_mrv, e_irdy, e_drdy, e_irv, e_drv, e_stall;
    e_mrv = 0; e_addr = 0; e_fcn = 0; e_typ = 0; e_wdata = 0;
    e_irdy = 0; e_drdy = 0; e_irv = 0; e_drv = 0; e_irdata = 0; e_drdata = 0; e_stall = 0;
    e_transfer = 0; e_pick_d = 0;
    if (reset) begin
      any  = imem_req_valid || dmem_req_valid;
      both = imem_req_valid && dmem_req_valid;
      idle = (m_pending == 0);
      if (idle) begin
        e_pick_d = dmem_req_valid && !(both && m_last_d);
        if (any) begin
          e_mrv = 1;
          if (e_pick_d) begin
            e_addr = dmem_req_addr; e_fcn = 32'(dmem_req_fcn);
            e_typ = 32'(dmem_req_typ); e_wdata = dmem_req_wdata;
            e_drdy = mem_req_ready;
          end else begin
            e_addr = imem_req_addr; e_fcn = 32'(M_XRD); e_typ = 32'(MT_W);
            e_irdy = mem_req_ready;
          end
        end
        e_transfer = any && mem_req_ready;
        e_stall = (any && !mem_req_ready) || both;
      end else begin
        e_irv = (m_pending == 1) && mem_resp_valid;
        e_drv = (m_pending == 2) && mem_resp_valid;
        if (e_irv) e_irdata = mem_resp_data;
        if (e_drv) e_drdata = mem_resp_data;
        e_stall = !mem_resp_valid;
      end
    end
    checkOutput("mem_req_valid",   32'(mem_req_valid),   32'(e_mrv));
    checkOutput("mem_req_addr",    mem_req_addr,         e_addr);
    checkOutput("mem_req_fcn",     32'(mem_req_fcn),     e_fcn);
    checkOutput("mem_req_typ",     32'(mem_req_typ),     e_typ);
    checkOutput("mem_req_wdata",   mem_req_wdata,        e_wdata);
    checkOutput("imem_req_ready",  32'(imem_req_ready),  32'(e_irdy));
    checkOutput("dmem_req_ready",  32'(dmem_req_ready),  32'(e_drdy));
    checkOutput("imem_resp_valid", 32'(imem_resp_valid), 32'(e_irv));
    checkOutput("imem_resp_data",  imem_resp_data,       e_irdata);
    checkOutput("dmem_resp_valid", 32'(dmem_resp_valid), 32'(e_drv));
    checkOutput("dmem_resp_data",  dmem_resp_data,       e_drdata);
    checkOutput("cmiss_stall",     32'(cmiss_stall),     32'(e_stall));
  endtask

  // Drives one cycle's inputs just after a falling edge, then checks before the next rising edge.
  task automatic applyStimulus(input logic rst_v, input logic iv, input logic [31:0] ia,
                               input logic dv, input logic [31:0] da, input MemoryWriteSignal fcn,
                               input MemoryMaskType typ, input logic [31:0] wd,
                               input logic mrdy, input logic rv, input logic [31:0] rd);
    reset          = rst_v;
    imem_req_valid = iv;
    imem_req_addr  = ia;
    dmem_req_valid = dv;
    dmem_req_addr  = da;
    dmem_req_fcn   = fcn;
    dmem_req_typ   = typ;
    dmem_req_wdata = wd;
    mem_req_ready  = mrdy;
    mem_resp_valid = rv;
    mem_resp_data  = rd;
    if (!rst_v) begin
      m_pending = 0;
      m_last_d  = 0;
    end
    #2;
    checkModel();
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      if (m_pending == 0 && e_transfer) begin
        m_pending = e_pick_d ? 2 : 1;
        m_last_d  = e_pick_d;
      end else if (m_pending != 0 && mem_resp_valid) begin
        m_pending = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] order_d;
    n_compared = 0;
    n_mismatched = 0;
    m_pending = 0;
    m_last_d = 0;
    reset = 0; imem_req_valid = 0; imem_req_addr = 0; dmem_req_valid = 0; dmem_req_addr = 0;
    dmem_req_fcn = M_XRD; dmem_req_typ = MT_X; dmem_req_wdata = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    @(negedge clk);

    // Reset holds everything at zero even with requests pending.
    applyStimulus(0, 1, 32'h100, 1, 32'h400, M_XWR, MT_W, 32'h55, 1, 1, 32'h1);
    checkOutput("reset_mem_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("reset_cmiss_stall", 32'(cmiss_stall), 32'd0);
    advance();

    // Single imem fetch with a next-cycle response.
    applyStimulus(1, 1, 32'h100, 0, 0, M_XRD, MT_X, 0, 1, 0, 0);
    checkOutput("fetch_addr", mem_req_addr, 32'h100);
    checkOutput("fetch_ready", 32'(imem_req_ready), 32'd1);
    advance();
    applyStimulus(1, 0, 0, 0, 0, M_XRD, MT_X, 0, 1, 1, 32'hDEADBEEF);
    checkOutput("fetch_resp_valid", 32'(imem_resp_valid), 32'd1);
    checkOutput("fetch_resp_data", imem_resp_data, 32'hDEADBEEF);
    checkOutput("fetch_dresp_valid", 32'(dmem_resp_valid), 32'd0);
    advance();

    // Repeated conflicts after reset alternate D, I, D, I.
    applyStimulus(0, 0, 0, 0, 0, M_XRD, MT_X, 0, 0, 0, 0);
    advance();
    order_d = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 1, 32'h200, 1, 32'h400, M_XWR, MT_W, 32'h55, 1, 0, 0);
      checkOutput("conflict_dmem_won", 32'(dmem_req_ready), 32'(order_d[k]));
      if (k % 2 == 0) checkOutput("conflict_store_wdata", mem_req_wdata, 32'h55);
      else checkOutput("conflict_fetch_addr", mem_req_addr, 32'h200);
      advance();
      applyStimulus(1, 0, 0, 0, 0, M_XRD, MT_X, 0, 1, 1, 32'hACC0 + 32'(k));
      advance();
    end

    // Backpressure: request held stable for three cycles, accepted on the fourth.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 0, 0, 1, 32'h800, M_XRD, MT_H, 0, 0, 0, 0);
      checkOutput("stall_req_valid", 32'(mem_req_valid), 32'd1);
      checkOutput("stall_req_addr", mem_req_addr, 32'h800);
      checkOutput("stall_dmem_ready", 32'(dmem_req_ready), 32'd0);
      checkOutput("stall_cmiss", 32'(cmiss_stall), 32'd1);
      advance();
    end
    applyStimulus(1, 0, 0, 1, 32'h800, M_XRD, MT_H, 0, 1, 0, 0);
    checkOutput("stall_accept", 32'(dmem_req_ready), 32'd1);
    advance();
    applyStimulus(1, 0, 0, 0, 0, M_XRD, MT_X, 0, 1, 1, 32'h1234);
    checkOutput("stall_resp_data", dmem_resp_data, 32'h1234);
    advance();

    // Slow fetch response while dmem waits; dmem wins the cycle after the response.
    applyStimulus(1, 1, 32'h300, 0, 0, M_XRD, MT_X, 0, 1, 0, 0);
    advance();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1, 0, 0, 1, 32'h900, M_XRD, MT_W, 0, 1, 0, 0);
      checkOutput("busy_req_valid", 32'(mem_req_valid), 32'd0);
      checkOutput("busy_dmem_ready", 32'(dmem_req_ready), 32'd0);
      advance();
    end
    applyStimulus(1, 0, 0, 1, 32'h900, M_XRD, MT_W, 0, 1, 1, 32'hCAFE);
    checkOutput("slow_iresp", 32'(imem_resp_valid), 32'd1);
    checkOutput("slow_dresp", 32'(dmem_resp_valid), 32'd0);
    advance();
    applyStimulus(1, 0, 0, 1, 32'h900, M_XRD, MT_W, 0, 1, 0, 0);
    checkOutput("after_slow_dgrant", 32'(dmem_req_ready), 32'd1);
    advance();
    applyStimulus(1, 0, 0, 0, 0, M_XRD, MT_X, 0, 1, 1, 32'h77);
    advance();

    // Reset in the middle of a store; a stray late response must be ignored.
    applyStimulus(1, 0, 0, 1, 32'hA00, M_XWR, MT_B, 32'h9, 1, 0, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, M_XRD, MT_X, 0, 1, 0, 0);
    checkOutput("midreset_stall", 32'(cmiss_stall), 32'd0);
    advance();
    applyStimulus(1, 0, 0, 0, 0, M_XRD, MT_X, 0, 1, 1, 32'hBAD);
    checkOutput("stray_dresp", 32'(dmem_resp_valid), 32'd0);
    checkOutput("stray_iresp", 32'(imem_resp_valid), 32'd0);
    advance();

    // Random traffic, including idle-state responses and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 99) != 0),
                    1'($urandom_range(0, 1)), $urandom(),
                    1'($urandom_range(0, 1)), $urandom(),
                    MemoryWriteSignal'($urandom_range(0, 1)),
                    MemoryMaskType'($urandom_range(0, 5)), $urandom(),
                    ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom());
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
